rr_arbiter: RTL and testbench

Round-robin arbiter with grant hold and timeout, sharing one downstream resource among `REQ_N` requesters. Each IDLE cycle it picks one pending request by lowest-set-bit isolation over a rotated request mask. It holds a registered one-hot grant until the owner releases it or a hold timeout fires, then advances the priority pointer past the served requester. It sits between requester blocks and a single shared datapath port.

---
 rtl/rr_arbiter.sv | 87 ++++++++
 tb/tb_rr_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant, grant hold and hold timeout
// Ports:
//   clk_i        clock, rising edge
//   srst_i       synchronous active-high reset
//   req_i        level-sensitive request vector, one bit per requester
//   done_i       current owner releases the resource
//   grant_o      registered one-hot grant, zero when idle
//   grant_val_o  registered, high while a grant is held
//   grant_idx_o  registered binary index of the owner, zero when idle
//   timeout_o    one-cycle pulse when a grant is forcibly revoked
module rr_arbiter #(
   parameter int REQ_N    = 8,
   parameter int MAX_HOLD = 16,
   parameter int IDX_W    = $clog2(REQ_N)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [REQ_N-1:0] req_i,
   input  logic             done_i,
   output logic [REQ_N-1:0] grant_o,
   output logic             grant_val_o,
   output logic [IDX_W-1:0] grant_idx_o,
   output logic             timeout_o
);
   localparam int HC_W = $clog2(MAX_HOLD + 1);
   typedef enum logic {IDLE, BUSY} state_t;
   state_t state, state_n;
   logic [IDX_W-1:0] ptr, ptr_n, own_idx, own_idx_n, sel_idx;
   logic [HC_W-1:0] hold_cnt, hold_cnt_n;
   logic [REQ_N-1:0] masked, pick, sel, grant_n;
   logic vol, forced, timeout_n;
   // requests at or above ptr win; fall back to the full vector when none are pending there
   always_comb begin
      masked = req_i & ~((REQ_N'(1) << ptr) - REQ_N'(1));
      pick = |masked ? masked : req_i;
      sel = pick & (~pick + REQ_N'(1));
      sel_idx = '0;
      for (int i = 0; i < REQ_N; i++) if (sel[i]) sel_idx = sel_idx | IDX_W'(i);
   end
   // done and timeout together count as a voluntary release
   assign vol = done_i | ~req_i[own_idx];
   assign forced = ~vol & (hold_cnt == HC_W'(MAX_HOLD - 1));
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      own_idx_n = own_idx;
      hold_cnt_n = hold_cnt;
      grant_n = grant_o;
      timeout_n = 1'b0;
      if (state == IDLE) begin
         if (|req_i) begin
            state_n = BUSY;
            own_idx_n = sel_idx;
            grant_n = sel;
            hold_cnt_n = '0;
         end
      end else if (vol | forced) begin
         state_n = IDLE;
         own_idx_n = '0;
         grant_n = '0;
         ptr_n = (own_idx == IDX_W'(REQ_N - 1)) ? '0 : own_idx + IDX_W'(1);
         timeout_n = forced;
      end else begin
         hold_cnt_n = hold_cnt + HC_W'(1);
      end
   end
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state <= IDLE;
         ptr <= '0;
         own_idx <= '0;
         hold_cnt <= '0;
         grant_o <= '0;
         grant_val_o <= 1'b0;
         timeout_o <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         own_idx <= own_idx_n;
         hold_cnt <= hold_cnt_n;
         grant_o <= grant_n;
         grant_val_o <= |grant_n;
         timeout_o <= timeout_n;
      end
   end
   assign grant_idx_o = own_idx;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: scoreboard bench for rr_arbiter with REQ_N=4, MAX_HOLD=4
module tb_rr_arbiter;
   logic clk = 1'b0;
   logic srst = 1'b1;
   logic [3:0] req = 4'b1111;
   logic done = 1'b0;
   logic [3:0] grant;
   logic grant_val;
   logic [1:0] grant_idx;
   logic timeout;
   int n_chk = 0;
   int n_fail = 0;
   typedef struct {
      bit is_end;
      logic [3:0] g;
      logic [1:0] idx;
      int len;
      logic to;
   } ev_t;
   ev_t q[$];
   rr_arbiter #(.REQ_N(4), .MAX_HOLD(4)) dut (
      .clk_i(clk), .srst_i(srst), .req_i(req), .done_i(done),
      .grant_o(grant), .grant_val_o(grant_val), .grant_idx_o(grant_idx), .timeout_o(timeout)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk_zero(input string name);
      chk({name, "_grant"}, 32'(grant), 0);
      chk({name, "_val"}, 32'(grant_val), 0);
      chk({name, "_idx"}, 32'(grant_idx), 0);
      chk({name, "_timeout"}, 32'(timeout), 0);
   endtask
   task automatic exp_grant(input logic [3:0] g, input logic [1:0] idx);
      q.push_back('{1'b0, g, idx, 0, 1'b0});
   endtask
   task automatic exp_end(input int len, input logic to);
      q.push_back('{1'b1, 4'b0, 2'b0, len, to});
   endtask
   // monitor: a rising grant_val is a grant event, a falling one is an end-of-ownership event
   initial begin
      bit prev, cur;
      int len;
      ev_t e;
      prev = 0;
      len = 0;
      forever begin
         @(negedge clk);
         cur = (grant_val === 1'b1);
         chk("val_consistent", 32'(grant_val), 32'(|grant));
         if (cur && !prev) begin
            if (q.size() == 0) chk("unexpected_grant", 32'(grant), 0);
            else begin
               e = q.pop_front();
               chk("grant_event_kind", 32'(e.is_end), 0);
               chk("grant_onehot", 32'(grant), 32'(e.g));
               chk("grant_idx", 32'(grant_idx), 32'(e.idx));
            end
            len = 1;
         end else if (cur) len++;
         else if (prev) begin
            if (q.size() == 0) chk("unexpected_release", 32'(len), 0);
            else begin
               e = q.pop_front();
               chk("end_event_kind", 32'(e.is_end), 1);
               chk("hold_len", 32'(len), 32'(e.len));
               chk("release_timeout", 32'(timeout), 32'(e.to));
            end
         end
         if (!(prev && !cur)) chk("timeout_quiet", 32'(timeout), 0);
         prev = cur;
      end
   end
   initial begin
      logic [3:0] rot [5];
      rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      tick();
      chk_zero("reset_a");
      tick();
      chk_zero("reset_b");
      srst = 1'b0;
      chk_zero("after_reset");
      for (int i = 0; i < 5; i++) begin
         exp_grant(rot[i], 2'(i % 4));
         exp_end(1, 1'b0);
         tick();
         done = 1'b1;
         tick();
         done = 1'b0;
      end
      req = 4'b0100;
      exp_grant(4'b0100, 2'd2);
      exp_end(1, 1'b0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req = 4'b0011;
      exp_grant(4'b0001, 2'd0);
      exp_end(1, 1'b0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req = 4'b0101;
      exp_grant(4'b0100, 2'd2);
      exp_end(1, 1'b0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req = 4'b0010;
      exp_grant(4'b0010, 2'd1);
      exp_end(4, 1'b1);
      exp_grant(4'b0010, 2'd1);
      exp_end(4, 1'b0);
      repeat (5) tick();
      chk("timeout_pulse", 32'(timeout), 1);
      chk("timeout_grant_zero", 32'(grant), 0);
      repeat (4) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("simul_no_timeout", 32'(timeout), 0);
      req = 4'b1000;
      exp_grant(4'b1000, 2'd3);
      exp_end(2, 1'b0);
      repeat (2) tick();
      req = 4'b0000;
      tick();
      chk_zero("owner_drop");
      req = 4'b0100;
      exp_grant(4'b0100, 2'd2);
      exp_end(2, 1'b0);
      repeat (2) tick();
      srst = 1'b1;
      req = 4'b1111;
      tick();
      chk_zero("mid_hold_reset");
      srst = 1'b0;
      exp_grant(4'b0001, 2'd0);
      exp_end(1, 1'b0);
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      req = 4'b0000;
      repeat (3) tick();
      chk("queue_empty", 32'(q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
